// File: rtl/eval_taper.sv
// Phase-tapered evaluation: blends middle-game and end-game scores by game phase,
// divides by 24 with a serial restoring divider and returns a side-to-move score.
module eval_taper #(
    parameter int EVAL_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         eval_valid,
    input  logic signed [EVAL_WIDTH-1:0] eval_mg,
    input  logic signed [EVAL_WIDTH-1:0] eval_eg,
    input  logic                         insufficient_material,
    input  logic [4:0]                   phase,
    input  logic                         white_to_move,
    input  logic                         clear_eval,
    output logic signed [EVAL_WIDTH-1:0] eval_out,
    output logic                         eval_out_valid
);
    localparam int PHASE_MAX = 24;
    localparam int IW        = EVAL_WIDTH + 6;
    localparam int DIV_BITS  = EVAL_WIDTH + 5;
    localparam int CNT_W     = $clog2(DIV_BITS + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL  = 3'd1;
    localparam logic [2:0] S_SUM  = 3'd2;
    localparam logic [2:0] S_DIV  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    function automatic logic [4:0] sat_phase(input logic [4:0] p);
        return (p > 5'(PHASE_MAX)) ? 5'(PHASE_MAX) : p;
    endfunction

    // Clamp to the output range; bits above the output sign must all match it.
    function automatic logic signed [EVAL_WIDTH-1:0] sat_out(input logic signed [IW-1:0] v);
        if (v[IW-1:EVAL_WIDTH-1] == {(IW-EVAL_WIDTH+1){1'b0}} ||
            v[IW-1:EVAL_WIDTH-1] == {(IW-EVAL_WIDTH+1){1'b1}})
            return v[EVAL_WIDTH-1:0];
        else if (v[IW-1])
            return {1'b1, {(EVAL_WIDTH-1){1'b0}}};
        else
            return {1'b0, {(EVAL_WIDTH-1){1'b1}}};
    endfunction

    logic [2:0]                   state_q, state_d;
    logic signed [EVAL_WIDTH-1:0] mg_q, mg_d, eg_q, eg_d;
    logic [4:0]                   phase_q, phase_d;
    logic                         wtm_q, wtm_d, insuf_q, insuf_d;
    logic signed [IW-1:0]         a_q, a_d, b_q, b_d;
    logic                         neg_q, neg_d;
    logic [DIV_BITS-1:0]          dvd_q, dvd_d;
    logic [4:0]                   rem_q, rem_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic signed [EVAL_WIDTH-1:0] out_q, out_d;
    logic                         vld_q, vld_d;

    logic signed [IW-1:0] mg_x, eg_x, p_x, pc_x, s_sum;
    logic signed [IW-1:0] q_mag, q_s, q_side, q_fin;
    logic [5:0]           rem_sh;
    logic                 q_bit;

    assign mg_x  = {{6{mg_q[EVAL_WIDTH-1]}}, mg_q};
    assign eg_x  = {{6{eg_q[EVAL_WIDTH-1]}}, eg_q};
    assign p_x   = {{(IW-5){1'b0}}, phase_q};
    assign pc_x  = {{(IW-5){1'b0}}, 5'(PHASE_MAX) - phase_q};
    assign s_sum = a_q + b_q;

    // One restoring step: shift in the next dividend bit, subtract 24 if it fits.
    assign rem_sh = {rem_q, dvd_q[DIV_BITS-1]};
    assign q_bit  = (rem_sh >= 6'd24);

    assign q_mag  = {1'b0, dvd_q};
    assign q_s    = neg_q ? -q_mag : q_mag;
    assign q_side = wtm_q ? q_s : -q_s;
    assign q_fin  = insuf_q ? '0 : q_side;

    always_comb begin
        state_d = state_q;
        mg_d    = mg_q;
        eg_d    = eg_q;
        phase_d = phase_q;
        wtm_d   = wtm_q;
        insuf_d = insuf_q;
        a_d     = a_q;
        b_d     = b_q;
        neg_d   = neg_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        vld_d   = vld_q;
        case (state_q)
            S_IDLE: begin
                if (eval_valid) begin
                    mg_d    = eval_mg;
                    eg_d    = eval_eg;
                    phase_d = sat_phase(phase);
                    wtm_d   = white_to_move;
                    insuf_d = insufficient_material;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                a_d     = mg_x * p_x;
                b_d     = eg_x * pc_x;
                state_d = S_SUM;
            end
            S_SUM: begin
                neg_d   = s_sum[IW-1];
                dvd_d   = DIV_BITS'(s_sum[IW-1] ? -s_sum : s_sum);
                rem_d   = '0;
                cnt_d   = '0;
                state_d = S_DIV;
            end
            S_DIV: begin
                if (cnt_q == CNT_W'(DIV_BITS)) begin
                    out_d   = sat_out(q_fin);
                    vld_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    rem_d = q_bit ? 5'(rem_sh - 6'd24) : rem_sh[4:0];
                    dvd_d = {dvd_q[DIV_BITS-2:0], q_bit};
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: ;
            default: state_d = S_IDLE;
        endcase
        if (clear_eval) begin
            state_d = S_IDLE;
            out_d   = '0;
            vld_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            mg_q    <= '0;
            eg_q    <= '0;
            phase_q <= '0;
            wtm_q   <= 1'b0;
            insuf_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            neg_q   <= 1'b0;
            dvd_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mg_q    <= mg_d;
            eg_q    <= eg_d;
            phase_q <= phase_d;
            wtm_q   <= wtm_d;
            insuf_q <= insuf_d;
            a_q     <= a_d;
            b_q     <= b_d;
            neg_q   <= neg_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
        end
    end

    assign eval_out       = out_q;
    assign eval_out_valid = vld_q;
endmodule
